// File: rtl/proc_control_if.sv
// Control bundle between the instruction sequencer and its surroundings:
// run/instruction inputs plus the datapath enables it produces.
interface proc_control_if;
    logic       run;
    logic [8:0] din;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       dinout;
    logic       irin;
    logic [1:0] operacao;
    logic       done;
    logic [1:0] tstep;

    modport master (
        output run, din,
        input  rin, rout, ain, gin, gout, dinout, irin, operacao, done, tstep
    );

    modport slave (
        input  run, din,
        output rin, rout, ain, gin, gout, dinout, irin, operacao, done, tstep
    );
endinterface

// File: rtl/proc_control.sv
// Four-step instruction sequencer for a simple 8-register processor
// (mv, mvi, add, sub); outputs decode the current step and instruction register.
module proc_control (
    input  logic          clk,
    input  logic          rst,
    proc_control_if.slave bus
);
    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } step_t;

    step_t      step_q;
    logic [8:0] ir_q;

    logic [2:0] opcode;
    logic [2:0] x_idx;
    logic [2:0] y_idx;
    logic [7:0] x_sel;
    logic [7:0] y_sel;
    logic       is_alu;

    logic [7:0] rin_w;
    logic [7:0] rout_w;
    logic       ain_w;
    logic       gin_w;
    logic       gout_w;
    logic       dinout_w;
    logic       irin_w;
    logic [1:0] operacao_w;
    logic       done_w;

    assign opcode = ir_q[8:6];
    assign x_idx  = ir_q[5:3];
    assign y_idx  = ir_q[2:0];
    assign is_alu = (opcode == 3'b010) || (opcode == 3'b011);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_reg_dec
            assign x_sel[gi] = (x_idx == 3'(gi));
            assign y_sel[gi] = (y_idx == 3'(gi));
        end
    endgenerate

    // IR is written only on the T0 -> T1 transition and held through the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= T0;
            ir_q   <= 9'h000;
        end else begin
            case (step_q)
                T0: begin
                    if (bus.run) begin
                        ir_q   <= bus.din;
                        step_q <= T1;
                    end
                end
                T1:      step_q <= is_alu ? T2 : T0;
                T2:      step_q <= T3;
                default: step_q <= T0;
            endcase
        end
    end

    always_comb begin
        rin_w      = 8'h00;
        rout_w     = 8'h00;
        ain_w      = 1'b0;
        gin_w      = 1'b0;
        gout_w     = 1'b0;
        dinout_w   = 1'b0;
        irin_w     = 1'b0;
        operacao_w = 2'b00;
        done_w     = 1'b0;
        case (step_q)
            T0: irin_w = bus.run;
            T1: begin
                case (opcode)
                    3'b000: begin
                        rout_w = y_sel;
                        rin_w  = x_sel;
                        done_w = 1'b1;
                    end
                    3'b001: begin
                        dinout_w = 1'b1;
                        rin_w    = x_sel;
                        done_w   = 1'b1;
                    end
                    3'b010, 3'b011: begin
                        rout_w = x_sel;
                        ain_w  = 1'b1;
                    end
                    default: done_w = 1'b1;
                endcase
            end
            T2: begin
                if (is_alu) begin
                    rout_w     = y_sel;
                    gin_w      = 1'b1;
                    operacao_w = (opcode == 3'b011) ? 2'b01 : 2'b00;
                end
            end
            default: begin
                if (is_alu) begin
                    gout_w = 1'b1;
                    rin_w  = x_sel;
                    done_w = 1'b1;
                end
            end
        endcase
    end

    assign bus.rin      = rin_w;
    assign bus.rout     = rout_w;
    assign bus.ain      = ain_w;
    assign bus.gin      = gin_w;
    assign bus.gout     = gout_w;
    assign bus.dinout   = dinout_w;
    assign bus.irin     = irin_w;
    assign bus.operacao = operacao_w;
    assign bus.done     = done_w;
    assign bus.tstep    = step_q;
endmodule

// File: tb/tb_proc_control.sv
// Scoreboard bench for proc_control: per-cycle expected output vectors are
// queued when an instruction is issued and compared as the cycles elapse.
module tb_proc_control;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    proc_control_if bus_if ();

    proc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    // {rin, rout, ain, gin, gout, dinout, irin, operacao, done, tstep}
    typedef logic [25:0] vec_t;

    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %07h expected %07h", tag, obs, exp);
        end
    endtask

    function automatic vec_t pack(input logic [7:0] rin, input logic [7:0] rout,
                                  input logic ain, input logic gin, input logic gout,
                                  input logic dinout, input logic irin,
                                  input logic [1:0] op, input logic done,
                                  input logic [1:0] tstep);
        return {rin, rout, ain, gin, gout, dinout, irin, op, done, tstep};
    endfunction

    function automatic vec_t obs_vec();
        return {bus_if.rin, bus_if.rout, bus_if.ain, bus_if.gin, bus_if.gout,
                bus_if.dinout, bus_if.irin, bus_if.operacao, bus_if.done, bus_if.tstep};
    endfunction

    // Expected cycle-by-cycle outputs, starting with the T0 cycle where Run=1.
    task automatic push_instr(input logic [8:0] din);
        logic [7:0] oh_x;
        logic [7:0] oh_y;
        oh_x = 8'h01 << din[5:3];
        oh_y = 8'h01 << din[2:0];
        exp_q.push_back(pack(8'h00, 8'h00, 0, 0, 0, 0, 1, 2'b00, 0, 2'd0));
        case (din[8:6])
            3'b000: exp_q.push_back(pack(oh_x, oh_y, 0, 0, 0, 0, 0, 2'b00, 1, 2'd1));
            3'b001: exp_q.push_back(pack(oh_x, 8'h00, 0, 0, 0, 1, 0, 2'b00, 1, 2'd1));
            3'b010, 3'b011: begin
                exp_q.push_back(pack(8'h00, oh_x, 1, 0, 0, 0, 0, 2'b00, 0, 2'd1));
                exp_q.push_back(pack(8'h00, oh_y, 0, 1, 0, 0, 0,
                                     (din[8:6] == 3'b011) ? 2'b01 : 2'b00, 0, 2'd2));
                exp_q.push_back(pack(oh_x, 8'h00, 0, 0, 1, 0, 0, 2'b00, 1, 2'd3));
            end
            default: exp_q.push_back(pack(8'h00, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1, 2'd1));
        endcase
    endtask

    // Called at a falling edge; leaves at the next falling edge.
    task automatic step_cycle(input string tag, input logic run, input logic [8:0] din);
        vec_t e;
        bus_if.run = run;
        bus_if.din = din;
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_val($sformatf("%s_t%0d", tag, e[1:0]), obs_vec(), e);
        end
        check_val({tag, "_bus_excl"},
                  32'(($countones(bus_if.rout) + int'(bus_if.gout) + int'(bus_if.dinout)) <= 1), 1);
        check_val({tag, "_onehot"}, 32'($onehot0(bus_if.rin) && $onehot0(bus_if.rout)), 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_instr(input string tag, input logic [8:0] din, input logic hold_run);
        int cyc;
        push_instr(din);
        cyc = exp_q.size();
        step_cycle(tag, 1'b1, din);
        while (exp_q.size() > 0) begin
            step_cycle(tag, hold_run ? 1'b1 : 1'(($urandom_range(0, 1))), 9'($urandom_range(0, 511)));
        end
        $display("instr %-8s din=%03b_%03b_%03b cycles=%0d", tag, din[8:6], din[5:3], din[2:0], cyc);
    endtask

    task automatic idle_cycle(input string tag);
        exp_q.push_back('0);
        step_cycle(tag, 1'b0, 9'($urandom_range(0, 511)));
    endtask

    initial begin
        logic [8:0] d;
        rst        = 1'b1;
        bus_if.run = 1'b0;
        bus_if.din = 9'h000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_state", obs_vec(), '0);
        bus_if.run = 1'b1;
        #1;
        check_val("reset_irin", obs_vec(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        check_val("reset_no_load", obs_vec(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        bus_if.run = 1'b0;
        rst = 1'b0;
        idle_cycle("idle");

        run_instr("mvi", 9'b001_010_000, 1'b0);
        run_instr("add", 9'b010_001_010, 1'b0);
        run_instr("sub", 9'b011_111_000, 1'b0);
        run_instr("nop", 9'b110_000_000, 1'b0);
        run_instr("mv", 9'b000_011_101, 1'b0);
        run_instr("add_xx", 9'b010_011_011, 1'b0);
        idle_cycle("idle");

        // Run held high across mv then add; next T0 follows Done directly.
        run_instr("b2b_mv", 9'b000_110_001, 1'b1);
        run_instr("b2b_add", 9'b010_100_111, 1'b1);
        idle_cycle("idle");

        // Reset landing between edges during add T2.
        push_instr(9'b010_001_010);
        step_cycle("rst_add", 1'b1, 9'b010_001_010);
        step_cycle("rst_add", 1'b0, 9'h1ff);
        bus_if.run = 1'b0;
        #1;
        check_val("rst_add_t2", obs_vec(), exp_q.pop_front());
        exp_q.delete();
        #1 rst = 1'b1;
        #1;
        check_val("rst_async_zero", obs_vec(), '0);
        @(posedge clk);
        @(negedge clk);
        check_val("rst_hold_t0", obs_vec(), '0);
        rst = 1'b0;
        idle_cycle("post_rst");
        idle_cycle("post_rst");
        run_instr("mvi_rst", 9'b001_010_000, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            d = 9'($urandom_range(0, 511));
            run_instr($sformatf("rnd%0d", i), d, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) idle_cycle("rnd_idle");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
